// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT32 sink-side blocks.
//   FFT_N / FFT_LOG2N / FFT_DW : frame size, index width, sample component width
//   cplx_t                     : packed complex sample {re, im}
//   state_e                    : frame reorder FSM states
//   bitrev()                   : bit reversal over FFT_LOG2N bits
//   wraddr()                   : capture write address for input position k
// Build option: FFT_REORDER_BITREV_EN -- when defined, wraddr() bit-reverses
// the input position; otherwise it is the identity (plain frame buffer).
// -----------------------------------------------------------------------------
package fft_pkg;

   localparam int FFT_N     = 32;
   localparam int FFT_LOG2N = 5;
   localparam int FFT_DW    = 16;

   typedef struct packed {
      logic signed [FFT_DW-1:0] re;
      logic signed [FFT_DW-1:0] im;
   } cplx_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DRAIN   = 2'd2
   } state_e;

   function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] k);
      logic [FFT_LOG2N-1:0] r;
      r = {FFT_LOG2N{1'b0}};
      for (int i = 0; i < FFT_LOG2N; i++) begin
         r[i] = k[FFT_LOG2N-1-i];
      end
      return r;
   endfunction

   // Bit reversal is its own inverse, so input position k of a bit-reversed
   // frame carries bin bitrev(k) and storing it there yields natural order.
   function automatic logic [FFT_LOG2N-1:0] wraddr(input logic [FFT_LOG2N-1:0] k);
`ifdef FFT_REORDER_BITREV_EN
      return bitrev(k);
`else
      return k;
`endif
   endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// -----------------------------------------------------------------------------
// fft_frame_ram
// One-frame sample store: synchronous write, asynchronous (combinational) read.
// Contents are not reset. A block RAM replacement would need one extra cycle
// of read latency absorbed by the caller.
// Ports:
//   clk      in  clock, rising edge
//   we_i     in  write enable
//   waddr_i  in  write address
//   wdata_i  in  write word
//   raddr_i  in  read address
//   rdata_o  out read word (combinational from raddr_i)
// -----------------------------------------------------------------------------
module fft_frame_ram
   import fft_pkg::*;
#(
   parameter int DEPTH = FFT_N,
   parameter int AW    = FFT_LOG2N,
   parameter int WIDTH = 2 * FFT_DW
) (
   input  logic             clk,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage write port.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_out_reorder.sv
// -----------------------------------------------------------------------------
// fft_out_reorder
// Captures one FFT output frame (streamed without backpressure) into a local
// buffer and replays it bin 0..N-1 over a valid/ready stream.
// Build option: FFT_REORDER_BITREV_EN -- defined: input is bit-reversed and is
// reordered to natural order; undefined: frame is replayed as received.
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-low reset
//   in_start_i    in   first sample of a frame (implies in_valid_i)
//   in_valid_i    in   input sample qualifier
//   in_re_i/im_i  in   signed input sample
//   out_valid_o   out  output sample valid
//   out_ready_i   in   downstream accept
//   out_re_o/im_o out  signed output sample
//   out_idx_o     out  bin index of current output sample
//   out_last_o    out  high with bin N-1
//   busy_o        out  high while capturing or draining
//   frame_drop_o  out  one-cycle pulse when an in_start during drain is rejected
// -----------------------------------------------------------------------------
module fft_out_reorder
   import fft_pkg::*;
#(
   parameter int N     = FFT_N,
   parameter int LOG2N = FFT_LOG2N,
   parameter int DW    = FFT_DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_start_i,
   input  logic                 in_valid_i,
   input  logic signed [DW-1:0] in_re_i,
   input  logic signed [DW-1:0] in_im_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic signed [DW-1:0] out_re_o,
   output logic signed [DW-1:0] out_im_o,
   output logic [LOG2N-1:0]     out_idx_o,
   output logic                 out_last_o,
   output logic                 busy_o,
   output logic                 frame_drop_o
);

   localparam logic [LOG2N-1:0] IDX_ZERO = {LOG2N{1'b0}};
   localparam logic [LOG2N-1:0] IDX_ONE  = LOG2N'(1);
   localparam logic [LOG2N-1:0] IDX_LAST = LOG2N'(N - 1);

   state_e                  state_q, state_d;
   logic [LOG2N-1:0]        wr_cnt_q, wr_cnt_d;
   logic [LOG2N-1:0]        rd_ptr_q, rd_ptr_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [DW-1:0]    out_re_q, out_re_d;
   logic signed [DW-1:0]    out_im_q, out_im_d;
   logic [LOG2N-1:0]        out_idx_q, out_idx_d;
   logic                    out_last_q, out_last_d;
   logic                    busy_q, busy_d;
   logic                    frame_drop_q, frame_drop_d;

   logic                    ram_we_s;
   logic [LOG2N-1:0]        ram_waddr_s;
   cplx_t                   ram_wdata_s;
   cplx_t                   ram_rdata_s;
   logic                    done_s;
   logic                    load_s;

   assign ram_wdata_s = {in_re_i, in_im_i};

   // Final sample is leaving this cycle.
   assign done_s = out_valid_q && out_ready_i && out_last_q;
   // Output register may take a new sample: empty or being drained, and the
   // last bin has not already been loaded.
   assign load_s = (state_q == DRAIN) && (!out_valid_q || out_ready_i)
                   && !(out_valid_q && out_last_q);

   fft_frame_ram #(
      .DEPTH (N),
      .AW    (LOG2N),
      .WIDTH (2 * DW)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we_s),
      .waddr_i (ram_waddr_s),
      .wdata_i (ram_wdata_s),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata_s)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_start_i) begin
               state_d = CAPTURE;
            end else begin
               state_d = IDLE;
            end
         end
         CAPTURE: begin
            if (in_start_i) begin
               state_d = CAPTURE;
            end else if (in_valid_i && (wr_cnt_q == IDX_LAST)) begin
               state_d = DRAIN;
            end else begin
               state_d = CAPTURE;
            end
         end
         DRAIN: begin
            if (done_s) begin
               state_d = IDLE;
            end else begin
               state_d = DRAIN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM outputs: buffer write control, counters and output register next values.
   always_comb begin
      wr_cnt_d     = wr_cnt_q;
      rd_ptr_d     = rd_ptr_q;
      ram_we_s     = 1'b0;
      ram_waddr_s  = wraddr(wr_cnt_q);
      out_valid_d  = out_valid_q;
      out_re_d     = out_re_q;
      out_im_d     = out_im_q;
      out_idx_d    = out_idx_q;
      out_last_d   = out_last_q;
      frame_drop_d = 1'b0;
      busy_d       = (state_d != IDLE);
      case (state_q)
         IDLE: begin
            if (in_start_i) begin
               ram_we_s    = 1'b1;
               ram_waddr_s = wraddr(IDX_ZERO);
               wr_cnt_d    = IDX_ONE;
            end else begin
               ram_we_s    = 1'b0;
            end
         end
         CAPTURE: begin
            if (in_start_i) begin
               // Abort the partial frame and restart from position 0.
               ram_we_s    = 1'b1;
               ram_waddr_s = wraddr(IDX_ZERO);
               wr_cnt_d    = IDX_ONE;
            end else if (in_valid_i) begin
               ram_we_s    = 1'b1;
               ram_waddr_s = wraddr(wr_cnt_q);
               if (wr_cnt_q == IDX_LAST) begin
                  wr_cnt_d = IDX_ZERO;
                  rd_ptr_d = IDX_ZERO;
               end else begin
                  wr_cnt_d = wr_cnt_q + IDX_ONE;
               end
            end else begin
               ram_we_s    = 1'b0;
            end
         end
         DRAIN: begin
            frame_drop_d = in_start_i;
            if (done_s) begin
               out_valid_d = 1'b0;
            end else if (load_s) begin
               out_valid_d = 1'b1;
               out_re_d    = ram_rdata_s.re;
               out_im_d    = ram_rdata_s.im;
               out_idx_d   = rd_ptr_q;
               out_last_d  = (rd_ptr_q == IDX_LAST);
               rd_ptr_d    = rd_ptr_q + IDX_ONE;
            end else begin
               out_valid_d = out_valid_q;
            end
         end
         default: begin
            ram_we_s = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_cnt_q     <= IDX_ZERO;
         rd_ptr_q     <= IDX_ZERO;
         out_valid_q  <= 1'b0;
         out_re_q     <= {DW{1'b0}};
         out_im_q     <= {DW{1'b0}};
         out_idx_q    <= IDX_ZERO;
         out_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_drop_q <= 1'b0;
      end else begin
         wr_cnt_q     <= wr_cnt_d;
         rd_ptr_q     <= rd_ptr_d;
         out_valid_q  <= out_valid_d;
         out_re_q     <= out_re_d;
         out_im_q     <= out_im_d;
         out_idx_q    <= out_idx_d;
         out_last_q   <= out_last_d;
         busy_q       <= busy_d;
         frame_drop_q <= frame_drop_d;
      end
   end

   assign out_valid_o  = out_valid_q;
   assign out_re_o     = out_re_q;
   assign out_im_o     = out_im_q;
   assign out_idx_o    = out_idx_q;
   assign out_last_o   = out_last_q;
   assign busy_o       = busy_q;
   assign frame_drop_o = frame_drop_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// -----------------------------------------------------------------------------
// tb_fft_out_reorder
// Scoreboard bench for fft_out_reorder: the producer task pushes the expected
// natural-order frame when it drives a frame; the consumer task pops and
// compares on every accepted output sample.
// -----------------------------------------------------------------------------
module tb_fft_out_reorder;

   localparam int N  = 32;
   localparam int LW = 5;
   localparam int DW = 16;

   typedef struct {
      int idx;
      int re;
      int im;
      bit last;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 in_start = 1'b0;
   logic                 in_valid = 1'b0;
   logic signed [DW-1:0] in_re = '0;
   logic signed [DW-1:0] in_im = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic signed [DW-1:0] out_re;
   logic signed [DW-1:0] out_im;
   logic [LW-1:0]        out_idx;
   logic                 out_last;
   logic                 busy;
   logic                 frame_drop;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   last_in_cyc = 0;

   fft_out_reorder dut (
      .clk          (clk),
      .rst          (rst),
      .in_start_i   (in_start),
      .in_valid_i   (in_valid),
      .in_re_i      (in_re),
      .in_im_i      (in_im),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_re_o     (out_re),
      .out_im_o     (out_im),
      .out_idx_o    (out_idx),
      .out_last_o   (out_last),
      .busy_o       (busy),
      .frame_drop_o (frame_drop)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic int brev(input int k);
      int r;
      r = 0;
      for (int i = 0; i < LW; i++) begin
         if (k[i]) r = r | (1 << (LW - 1 - i));
      end
      return r;
   endfunction

   function automatic int waddr_m(input int k);
`ifdef FFT_REORDER_BITREV_EN
      return brev(k);
`else
      return k;
`endif
   endfunction

   // Producer: optional aborted partial frame, then a full frame whose position p
   // carries re=brev(p)+off, im=-(brev(p)+off); optional idle gaps.
   task automatic send_frame(input int off, input int junk, input int ga_pos, input int ga_len,
                             input int gb_pos, input int gb_len);
      int mre[N];
      int mim[N];
      exp_t e;
      for (int p = 0; p < junk; p++) begin
         @(posedge clk); #1;
         in_start = (p == 0);
         in_valid = 1'b1;
         in_re    = 16'(p + 50);
         in_im    = 16'(p + 60);
      end
      for (int p = 0; p < N; p++) begin
         @(posedge clk); #1;
         in_start = (p == 0);
         in_valid = 1'b1;
         in_re    = 16'(brev(p) + off);
         in_im    = 16'(-(brev(p) + off));
         mre[waddr_m(p)] = brev(p) + off;
         mim[waddr_m(p)] = -(brev(p) + off);
         if (p == N - 1) last_in_cyc = cyc;
         if (p == ga_pos || p == gb_pos) begin
            for (int g = 0; g < ((p == ga_pos) ? ga_len : gb_len); g++) begin
               @(posedge clk); #1;
               in_start = 1'b0;
               in_valid = 1'b0;
               in_re    = 16'($urandom);
               in_im    = 16'($urandom);
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         e.idx = i; e.re = mre[i]; e.im = mim[i]; e.last = (i == N - 1);
         sb.push_back(e);
      end
      @(posedge clk); #1;
      in_start = 1'b0;
      in_valid = 1'b0;
   endtask

   // Consumer: pat 0 = always ready, 1 = ready 1,0,0 repeating. Optionally
   // injects an in_start at bin drop_at, or asserts reset at bin rst_at.
   task automatic receive(input int pat, input int drop_at, input int rst_at,
                          output int first_cyc, output int n_got);
      logic [38:0] snap, held;
      bit   started, stall, done, inj, injected, rdy;
      int   k, drops, busy_low, budget;
      exp_t e;
      started = 0; stall = 0; done = 0; inj = 0; injected = 0;
      k = 0; drops = 0; busy_low = 0; budget = 0;
      held = '0;
      first_cyc = -1;
      n_got = 0;
      while (!done && budget < 600) begin
         @(posedge clk); #1;
         budget++;
         snap = {out_valid, out_re, out_im, out_idx, out_last};
         if (inj) begin
            in_start = 1'b0;
            in_valid = 1'b0;
            inj = 0;
         end
         if (stall) begin
            n_cmp++;
            if (snap !== held) begin
               n_err++;
               $display("FAIL stall_hold: got %h want %h", snap, held);
            end
         end
         if (busy) started = 1;
         else if (started) busy_low++;
         if (frame_drop) drops++;
         if (out_valid && first_cyc < 0) first_cyc = cyc;
         if (rst_at >= 0 && out_valid && out_idx == LW'(rst_at)) begin
            rst = 1'b0;
            #1;
            n_cmp++;
            if ({out_valid, out_re, out_im, out_idx, out_last, busy, frame_drop} !== 41'd0) begin
               n_err++;
               $display("FAIL async_reset_outputs: got v=%b re=%0d im=%0d idx=%0d last=%b busy=%b drop=%b want all 0",
                        out_valid, out_re, out_im, out_idx, out_last, busy, frame_drop);
            end
            out_ready = 1'b0;
            done = 1;
         end else begin
            rdy = (pat == 0) ? 1'b1 : (k % 3 == 0);
            k++;
            out_ready = rdy;
            if (out_valid && rdy) begin
               n_got++;
               n_cmp++;
               if (sb.size() == 0) begin
                  n_err++;
                  $display("FAIL extra_output: got idx=%0d want no output", out_idx);
               end else begin
                  e = sb.pop_front();
                  if (out_idx !== LW'(e.idx) || out_re !== 16'(e.re) || out_im !== 16'(e.im)
                      || out_last !== e.last) begin
                     n_err++;
                     $display("FAIL sample: got idx=%0d re=%0d im=%0d last=%b want idx=%0d re=%0d im=%0d last=%b",
                              out_idx, out_re, out_im, out_last, e.idx, e.re, e.im, e.last);
                  end
               end
               if (out_last) done = 1;
            end
            if (drop_at >= 0 && !injected && out_valid && out_idx == LW'(drop_at)) begin
               in_start = 1'b1;
               in_valid = 1'b1;
               inj = 1;
               injected = 1;
            end
            stall = out_valid && !rdy;
            held  = snap;
         end
      end
      n_cmp++;
      if (!done) begin
         n_err++;
         $display("FAIL drain_timeout: got %0d samples want frame completion", n_got);
      end
      if (rst_at < 0) begin
         n_cmp++;
         if (drops !== ((drop_at >= 0) ? 1 : 0)) begin
            n_err++;
            $display("FAIL frame_drop_count: got %0d want %0d", drops, (drop_at >= 0) ? 1 : 0);
         end
         n_cmp++;
         if (busy_low !== 0) begin
            n_err++;
            $display("FAIL busy_continuous: got %0d low cycles want 0", busy_low);
         end
         @(posedge clk); #1;
         out_ready = 1'b0;
         n_cmp++;
         if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL back_to_idle: got busy=%b valid=%b want 0 0", busy, out_valid);
         end
      end
   endtask

   task automatic run_frame(input int off, input int junk, input int pat, input int drop_at,
                            input int ga_pos, input int ga_len, input int gb_pos, input int gb_len,
                            input string name);
      int fc, ng;
      fork
         send_frame(off, junk, ga_pos, ga_len, gb_pos, gb_len);
         receive(pat, drop_at, -1, fc, ng);
      join
      n_cmp++;
      if (ng !== N) begin
         n_err++;
         $display("FAIL %s_count: got %0d want %0d", name, ng, N);
      end
      n_cmp++;
      if (sb.size() !== 0) begin
         n_err++;
         $display("FAIL %s_leftover: got %0d unpopped want 0", name, sb.size());
      end
      sb.delete();
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, out_re, out_im, out_idx, out_last, busy, frame_drop} !== 41'd0) begin
         n_err++;
         $display("FAIL reset_state: got v=%b re=%0d im=%0d idx=%0d busy=%b want all 0",
                  out_valid, out_re, out_im, out_idx, busy);
      end
      @(negedge clk);
      rst = 1'b1;
      // in_valid without in_start in IDLE must be ignored.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         in_re    = 16'(i + 7);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL idle_ignore_valid: got busy=%b valid=%b want 0 0", busy, out_valid);
      end
   endtask

   task automatic test_basic();
      int fc, ng;
      fork
         send_frame(0, 0, -1, 0, -1, 0);
         receive(0, -1, -1, fc, ng);
      join
      n_cmp++;
      if (ng !== N) begin
         n_err++;
         $display("FAIL basic_count: got %0d want %0d", ng, N);
      end
      n_cmp++;
      if (fc - last_in_cyc !== 2) begin
         n_err++;
         $display("FAIL basic_latency: got %0d want 2", fc - last_in_cyc);
      end
      sb.delete();
      repeat (2) @(posedge clk);
   endtask

   task automatic test_backpressure();
      run_frame(0, 0, 1, -1, -1, 0, -1, 0, "backpressure");
   endtask

   task automatic test_gaps();
      run_frame(0, 0, 0, -1, 10, 3, 20, 1, "gaps");
   endtask

   task automatic test_drop();
      run_frame(0, 0, 0, 5, -1, 0, -1, 0, "drop");
   endtask

   task automatic test_restart();
      run_frame(100, 12, 0, -1, -1, 0, -1, 0, "restart");
   endtask

   task automatic test_async_reset();
      int fc, ng;
      fork
         send_frame(0, 0, -1, 0, -1, 0);
         receive(0, -1, 7, fc, ng);
      join
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      run_frame(0, 0, 0, -1, -1, 0, -1, 0, "after_reset");
   endtask

   task automatic test_back_to_back();
      run_frame(3, 0, 0, -1, -1, 0, -1, 0, "b2b_a");
      run_frame(200, 0, 1, -1, -1, 0, -1, 0, "b2b_b");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_gaps();
      test_drop();
      test_restart();
      test_async_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Sink-side companion to the FFT32 core.
- Captures one N-point FFT output frame, which the core streams in bit-reversed order with no backpressure.
- Stores the frame in a local buffer and replays it in natural order (bin 0..N-1) over a valid/ready stream.
- Sits between the FFT core's out_re/out_im/done outputs and downstream consumers (magnitude, serializer).

Parameters:
- N, 32, FFT points per frame (power of two).
- LOG2N, 5, log2(N); address/index width.
- DW, 16, signed sample width per component.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_start  in  1  pulse coincident with the first sample of a frame (driven by FFT done).
- in_valid  in  1  sample qualifier for in_re/in_im; in_start implies in_valid.
- in_re  in  DW  signed real part, bit-reversed order.
- in_im  in  DW  signed imaginary part.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accept.
- out_re  out  DW  signed real part, natural order.
- out_im  out  DW  signed imaginary part.
- out_idx  out  LOG2N  bin index of the current output sample.
- out_last  out  1  high with bin N-1.
- busy  out  1  high in CAPTURE or DRAIN.
- frame_drop  out  1  one-cycle pulse when an in_start is rejected.

Behaviour:
- Reset (rst=0, async): state=IDLE; wr_cnt=0, rd_ptr=0; out_valid, out_re, out_im, out_idx, out_last, busy, frame_drop all 0. Buffer contents are not reset (don't-care).
- Buffer: N entries x 2*DW, written one per cycle, read combinationally into the output register.
- States:
  - IDLE:
    - in_start=1 writes the sample at wraddr(0), sets wr_cnt=1, goes to CAPTURE.
    - in_valid without in_start is ignored.
  - CAPTURE:
    - Each cycle with in_valid=1 writes at wraddr(wr_cnt), then wr_cnt++.
    - in_valid=0 holds (gap tolerated, no write).
    - When the N-th write lands (wr_cnt==N-1 with in_valid), go to DRAIN with rd_ptr=0.
    - in_start during CAPTURE aborts the current frame: restart at wraddr(0), wr_cnt=1, no frame_drop.
  - DRAIN:
    - Output register loads buf[rd_ptr], out_idx=rd_ptr, out_last=(rd_ptr==N-1), out_valid=1 whenever !out_valid || out_ready; then rd_ptr++.
    - out_valid/out_re/out_im/out_idx/out_last hold stable while out_valid && !out_ready.
    - After the sample with out_last is accepted (out_valid && out_ready && out_last), out_valid=0 and state=IDLE. The next frame may start the same cycle out_valid drops.
    - in_start during DRAIN is ignored; frame_drop=1 for one cycle; drain continues unaffected.
- Latency: first out_valid asserts 1 cycle after entering DRAIN, i.e. 2 cycles after the N-th input sample. Throughput is 1 sample/cycle when out_ready=1.
- wraddr(k) = bit-reverse of k over LOG2N bits (see Optional Feature). Bit-reversal is an involution, so bin b lands at address b.
- busy = (state != IDLE).
- No arithmetic on data; widths pass through unchanged.

Optional Feature:
- Macro: FFT_REORDER_BITREV_EN.
- Defined: wraddr(k) = bitrev(k); the block reorders bit-reversed input to natural order.
- Undefined: wraddr(k) = k; the block is a plain frame buffer with identical handshake and timing, for cores that already emit natural order.

Decomposition:
- Shared package fft_pkg holds:
  - constants FFT_N=32, FFT_LOG2N=5, FFT_DW=16;
  - complex sample typedef cplx_t {re, im}, each signed DW;
  - state enum {IDLE, CAPTURE, DRAIN};
  - bitrev function over LOG2N bits.
- One natural sub-module, fft_frame_ram: N x 2*DW, synchronous write, asynchronous read. This allows later replacement with a block RAM plus a 1-cycle read adjust.

Test Plan:
1. Basic reorder: N=32; in_start then 32 samples, position p carrying re=bitrev(p), im=-bitrev(p); out_ready=1 -> 32 outputs with out_idx=i, re=i, im=-i; out_last only at i=31; first out_valid 2 cycles after last input.
2. Backpressure: repeat scenario 1 with out_ready toggling 1,0,0,1,... -> no loss or duplication; outputs stable while stalled; out_idx strictly 0..31.
3. Input gaps: in_valid low for 3 cycles after sample 10 and 1 cycle after sample 20 -> output identical to scenario 1.
4. Drop: in_start pulse during DRAIN (out_idx=5) -> frame_drop high exactly 1 cycle; the remaining 26 outputs are unchanged; state returns to IDLE after bin 31.
5. Restart: in_start at capture sample 12, then a full new frame with values +100 -> outputs are re=i+100, busy continuous, no frame_drop.
6. Async reset mid-DRAIN (out_idx=7) -> all outputs 0 immediately, busy=0; a fresh frame afterwards reorders correctly. Without FFT_REORDER_BITREV_EN, scenario 1 input is emitted unreordered (out_idx=i, re=bitrev(i)).
